// File: rtl/icache_mem_ctrl_if.sv
// Bus bundle between the memory controller and its environment
// (fetcher, LSB, byte-wide RAM/UART port and global control).
interface icache_mem_ctrl_if;
  logic        rdy;
  logic        rob_clear;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        in_fetcher_ready;
  logic [31:0] instr_addr;
  logic        out_fetcher_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;
  logic        in_lsb_ready;
  logic [2:0]  op_in;
  logic        is_store;
  logic [31:0] data_addr_in;
  logic [31:0] data_in;
  logic        welcome_lsb;
  logic        out_lsb_ready;
  logic [31:0] data_out;

  modport master (
    input  rdy, rob_clear, mem_din, io_buffer_full,
           in_fetcher_ready, instr_addr,
           in_lsb_ready, op_in, is_store, data_addr_in, data_in,
    output mem_dout, mem_a, mem_wr,
           out_fetcher_ready, instr_out, instr_addr_out,
           welcome_lsb, out_lsb_ready, data_out
  );

  modport slave (
    output rdy, rob_clear, mem_din, io_buffer_full,
           in_fetcher_ready, instr_addr,
           in_lsb_ready, op_in, is_store, data_addr_in, data_in,
    input  mem_dout, mem_a, mem_wr,
           out_fetcher_ready, instr_out, instr_addr_out,
           welcome_lsb, out_lsb_ready, data_out
  );
endinterface

// File: rtl/icache_mem_ctrl.sv
// Direct-mapped instruction cache plus byte-serial load/store engine
// sharing one byte-wide RAM/UART port.
module icache_mem_ctrl #(
  parameter int          LINES      = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input logic            clk,
  input logic            rst,
  icache_mem_ctrl_if.master bus
);
  localparam int LINE_BYTES = 4 * LINE_WORDS;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(LINES);
  localparam int TAG_W      = 32 - OFF_W - IDX_W;
  localparam int CW         = $clog2(LINE_BYTES + 1);
  localparam logic [CW-1:0] FILL_N = CW'(LINE_BYTES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STORE = 3'd2;
  localparam logic [2:0] S_IFILL = 3'd3;
  localparam logic [2:0] S_IRESP = 3'd4;

  logic [2:0]                  state;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               nbytes;
  logic [2:0]                  op;
  logic [31:0]                 addr;
  logic [3:0][7:0]             wdata;
  logic [3:0][7:0]             ldbuf;
  logic [31:0]                 fetch_addr;
  logic [31:0]                 fill_base;
  logic                        stalled_q;
  logic [LINES-1:0]            valid;
  logic [TAG_W-1:0]            tags  [LINES];
  logic [LINE_BYTES*8-1:0]     lines [LINES];

  logic [31:0]       cur_base, st_addr, instr_w, ld_ext;
  logic [CW-1:0]     lim;
  logic              busy, replay, issue, st_blk, st_hit, f_hit;
  logic              ld_done, st_done, lsb_pulse, fetch_pulse;
  logic [IDX_W-1:0]  f_idx, l_idx, st_idx;
  logic [3:0][7:0]   raw;
  logic [OFF_W-1:0]  f_off;
  logic [LINE_BYTES*8-1:0] line_flat;

  always_comb begin
    busy     = (state == S_LOAD) || (state == S_STORE) || (state == S_IFILL);
    cur_base = (state == S_IFILL) ? fill_base : addr;
    lim      = (state == S_IFILL) ? FILL_N : nbytes;
    // After a rdy pause the read issued before it is lost: re-issue it first.
    replay   = stalled_q && (cnt != '0) && ((state == S_LOAD) || (state == S_IFILL));
    issue    = busy && (cnt < lim);

    st_addr  = addr + 32'(cnt);
    st_blk   = (st_addr >= IO_BASE) && bus.io_buffer_full;
    st_idx   = st_addr[OFF_W +: IDX_W];
    st_hit   = valid[st_idx] && (tags[st_idx] == st_addr[31 -: TAG_W]);

    f_idx    = bus.instr_addr[OFF_W +: IDX_W];
    f_hit    = valid[f_idx] && (tags[f_idx] == bus.instr_addr[31 -: TAG_W]);

    l_idx     = fetch_addr[OFF_W +: IDX_W];
    f_off     = fetch_addr[OFF_W-1:0];
    line_flat = lines[l_idx];
    instr_w   = line_flat[32*int'(f_off >> 2) +: 32];

    raw = ldbuf;
    raw[2'(nbytes - 1'b1)] = bus.mem_din;
    case (op[1:0])
      2'd0:    ld_ext = {{24{~op[2] & raw[0][7]}}, raw[0]};
      2'd1:    ld_ext = {{16{~op[2] & raw[1][7]}}, raw[1], raw[0]};
      default: ld_ext = raw;
    endcase

    ld_done     = (state == S_LOAD) && (cnt == nbytes) && !replay;
    st_done     = (state == S_STORE) && (cnt == nbytes);
    lsb_pulse   = bus.rdy && ((ld_done && !bus.rob_clear) || st_done);
    fetch_pulse = bus.rdy && (state == S_IRESP) && !bus.rob_clear;

    bus.mem_a = '0;
    if (replay)     bus.mem_a = cur_base + 32'(cnt) - 32'd1;
    else if (issue) bus.mem_a = cur_base + 32'(cnt);
    bus.mem_dout = (state == S_STORE && issue) ? wdata[2'(cnt)] : 8'h00;
    bus.mem_wr   = bus.rdy && (state == S_STORE) && issue && !st_blk;

    bus.welcome_lsb       = (state == S_IDLE);
    bus.out_lsb_ready     = lsb_pulse;
    bus.data_out          = (lsb_pulse && ld_done) ? ld_ext : 32'h0;
    bus.out_fetcher_ready = fetch_pulse;
    bus.instr_out         = fetch_pulse ? instr_w : 32'h0;
    bus.instr_addr_out    = fetch_pulse ? fetch_addr : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      nbytes     <= '0;
      op         <= '0;
      addr       <= '0;
      wdata      <= '0;
      ldbuf      <= '0;
      fetch_addr <= '0;
      fill_base  <= '0;
      stalled_q  <= 1'b0;
      valid      <= '0;
      for (int i = 0; i < LINES; i++) tags[i] <= '0;
    end else begin
      stalled_q <= !bus.rdy;
      if (bus.rdy) begin
        case (state)
          S_IDLE: if (!bus.rob_clear) begin
            if (bus.in_lsb_ready) begin
              addr   <= bus.data_addr_in;
              wdata  <= bus.data_in;
              op     <= bus.op_in;
              nbytes <= (bus.op_in[1:0] == 2'd0) ? CW'(1) :
                        (bus.op_in[1:0] == 2'd1) ? CW'(2) : CW'(4);
              cnt    <= '0;
              state  <= bus.is_store ? S_STORE : S_LOAD;
            end else if (bus.in_fetcher_ready) begin
              fetch_addr <= bus.instr_addr;
              if (f_hit) state <= S_IRESP;
              else begin
                fill_base    <= {bus.instr_addr[31:OFF_W], {OFF_W{1'b0}}};
                valid[f_idx] <= 1'b0;
                cnt          <= '0;
                state        <= S_IFILL;
              end
            end
          end
          S_LOAD: begin
            if (bus.rob_clear) state <= S_IDLE;
            else if (!replay) begin
              if (cnt != '0) ldbuf[2'(cnt - 1'b1)] <= bus.mem_din;
              if (cnt == nbytes) state <= S_IDLE;
              else               cnt   <= cnt + 1'b1;
            end
          end
          // Stores are commit-time only, so a flush never cuts them short.
          S_STORE: begin
            if (cnt == nbytes) state <= S_IDLE;
            else if (!st_blk) begin
              cnt <= cnt + 1'b1;
              if (st_hit) valid[st_idx] <= 1'b0;
            end
          end
          S_IFILL: begin
            if (bus.rob_clear) state <= S_IDLE;
            else if (!replay && cnt == FILL_N) begin
              valid[l_idx] <= 1'b1;
              tags[l_idx]  <= fetch_addr[31 -: TAG_W];
              state        <= S_IRESP;
            end else if (!replay) cnt <= cnt + 1'b1;
          end
          S_IRESP: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Line data needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst && bus.rdy && state == S_IFILL && !bus.rob_clear && !replay && cnt != '0)
      lines[l_idx][8*int'(OFF_W'(cnt - 1'b1)) +: 8] <= bus.mem_din;
  end
endmodule

// File: tb/tb_icache_mem_ctrl.sv
// Directed bench for icache_mem_ctrl: hand-computed latencies, data and
// RAM write sequences against a simple byte RAM model.
module tb_icache_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_mem_ctrl_if bus();
  icache_mem_ctrl #(.LINES(16), .LINE_WORDS(4), .IO_BASE(32'h30000))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        ram[18'h1000 + 18'(i)] <= 8'(16 + i);
        ram[18'h1040 + 18'(i)] <= 8'(64 + i);
      end
      ram[18'h2000] <= 8'h01;
      ram[18'h2001] <= 8'h80;
      ram[18'h2003] <= 8'h80;
    end else if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[17:0]];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          nact, nwr, wr1_c;
  logic [31:0] first_a, last_a;
  logic [31:0] wa[$];
  logic [7:0]  wd[$];

  task automatic do_op(input bit lsb, input bit st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wdat,
                       input int rob_at, input int full_n, input int rlo, input int rhi,
                       input int maxc, output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    if (lsb) begin
      bus.in_lsb_ready = 1'b1; bus.is_store = st; bus.op_in = op;
      bus.data_addr_in = a; bus.data_in = wdat;
    end else begin
      bus.in_fetcher_ready = 1'b1; bus.instr_addr = a;
    end
    @(posedge clk); #1;
    bus.in_lsb_ready = 1'b0; bus.in_fetcher_ready = 1'b0;
    lat = -1; rd = 32'h0; nact = 0; nwr = 0; wr1_c = -1;
    first_a = 32'h0; last_a = 32'h0;
    wa.delete(); wd.delete();
    for (int c = 1; c <= maxc; c++) begin
      bus.rob_clear      = (c == rob_at);
      bus.io_buffer_full = (c <= full_n);
      bus.rdy            = !(c >= rlo && c <= rhi);
      @(negedge clk);
      if (bus.mem_a != 32'h0) begin
        nact++;
        if (nact == 1) first_a = bus.mem_a;
        last_a = bus.mem_a;
      end
      if (bus.mem_wr) begin
        nwr++;
        if (wr1_c < 0) wr1_c = c;
        wa.push_back(bus.mem_a); wd.push_back(bus.mem_dout);
      end
      if (bus.out_fetcher_ready || bus.out_lsb_ready) begin
        lat = c;
        rd  = lsb ? bus.data_out : bus.instr_out;
        break;
      end
      @(posedge clk); #1;
    end
    bus.rob_clear = 1'b0; bus.io_buffer_full = 1'b0; bus.rdy = 1'b1;
  endtask

  int          lat, lsb_c, f_c;
  logic [31:0] rd, ld_v, fi_v;

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.rob_clear = 1'b0; bus.io_buffer_full = 1'b0;
    bus.in_fetcher_ready = 1'b0; bus.instr_addr = 32'h0;
    bus.in_lsb_ready = 1'b0; bus.op_in = 3'd0; bus.is_store = 1'b0;
    bus.data_addr_in = 32'h0; bus.data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
    chk("rst_welcome", 32'(bus.welcome_lsb), 32'h1);
    chk("rst_ready", {30'h0, bus.out_fetcher_ready, bus.out_lsb_ready}, 32'h0);

    // cold miss: full line refill
    do_op(0, 0, 3'd0, 32'h1000, 32'h0, 0, 0, 0, 0, 40, lat, rd);
    chk("miss_lat", 32'(lat), 32'd18);
    chk("miss_word", rd, 32'h13121110);
    chk("miss_nreads", 32'(nact), 32'd16);
    chk("miss_first_a", first_a, 32'h1000);
    chk("miss_last_a", last_a, 32'h100F);

    do_op(0, 0, 3'd0, 32'h1004, 32'h0, 0, 0, 0, 0, 40, lat, rd);
    chk("hit_lat", 32'(lat), 32'd1);
    chk("hit_word", rd, 32'h17161514);
    chk("hit_no_mem", 32'(nact), 32'd0);

    do_op(1, 0, 3'd0, 32'h2003, 32'h0, 0, 0, 0, 0, 20, lat, rd);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_data", rd, 32'hFFFFFF80);
    do_op(1, 0, 3'd4, 32'h2003, 32'h0, 0, 0, 0, 0, 20, lat, rd);
    chk("lbu_data", rd, 32'h00000080);
    do_op(1, 0, 3'd1, 32'h2000, 32'h0, 0, 0, 0, 0, 20, lat, rd);
    chk("lh_lat", 32'(lat), 32'd3);
    chk("lh_data", rd, 32'hFFFF8001);
    do_op(1, 0, 3'd2, 32'h1000, 32'h0, 0, 0, 0, 0, 20, lat, rd);
    chk("lw_lat", 32'(lat), 32'd5);
    chk("lw_data", rd, 32'h13121110);

    // store into a cached line must invalidate it
    do_op(1, 1, 3'd2, 32'h1004, 32'hDEADBEEF, 0, 0, 0, 0, 20, lat, rd);
    chk("sw_lat", 32'(lat), 32'd5);
    chk("sw_nwr", 32'(nwr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ew;
      logic [7:0]  eb;
      ew = 32'hDEADBEEF;
      eb = ew[8*i +: 8];
      if (i < wa.size()) begin
        chk($sformatf("sw_a%0d", i), wa[i], 32'h1004 + 32'(i));
        chk($sformatf("sw_d%0d", i), 32'(wd[i]), 32'(eb));
      end else chk($sformatf("sw_missing%0d", i), 32'(wa.size()), 32'd4);
    end
    do_op(0, 0, 3'd0, 32'h1000, 32'h0, 0, 0, 0, 0, 40, lat, rd);
    chk("smc_refetch_lat", 32'(lat), 32'd18);
    chk("smc_refetch_word", rd, 32'h13121110);
    do_op(0, 0, 3'd0, 32'h1004, 32'h0, 0, 0, 0, 0, 40, lat, rd);
    chk("smc_hit_lat", 32'(lat), 32'd1);
    chk("smc_hit_word", rd, 32'hDEADBEEF);

    // UART back-pressure for three cycles
    do_op(1, 1, 3'd0, 32'h30000, 32'h0000005A, 0, 3, 0, 0, 20, lat, rd);
    chk("io_lat", 32'(lat), 32'd5);
    chk("io_nwr", 32'(nwr), 32'd1);
    chk("io_wr_cycle", 32'(wr1_c), 32'd4);
    chk("io_byte", (wd.size() > 0) ? 32'(wd[0]) : 32'hFFFFFFFF, 32'h5A);

    // flush on the 5th refill cycle: no pulse, line stays invalid
    do_op(0, 0, 3'd0, 32'h1040, 32'h0, 5, 0, 0, 0, 30, lat, rd);
    chk("rob_fill_nopulse", 32'(lat), 32'hFFFFFFFF);
    do_op(0, 0, 3'd0, 32'h1040, 32'h0, 0, 0, 0, 0, 40, lat, rd);
    chk("rob_refill_lat", 32'(lat), 32'd18);
    chk("rob_refill_word", rd, 32'h43424140);
    do_op(0, 0, 3'd0, 32'h1000, 32'h0, 0, 0, 0, 0, 40, lat, rd);
    chk("rob_other_hit", 32'(lat), 32'd1);

    do_op(1, 1, 3'd2, 32'h2100, 32'h11223344, 2, 0, 0, 0, 20, lat, rd);
    chk("rob_store_lat", 32'(lat), 32'd5);
    chk("rob_store_nwr", 32'(nwr), 32'd4);

    // simultaneous requests: LSB first, fetch held until accepted
    @(posedge clk); #1;
    bus.in_lsb_ready = 1'b1; bus.is_store = 1'b0; bus.op_in = 3'd4;
    bus.data_addr_in = 32'h2003;
    bus.in_fetcher_ready = 1'b1; bus.instr_addr = 32'h1004;
    @(posedge clk); #1;
    bus.in_lsb_ready = 1'b0;
    lsb_c = -1; f_c = -1; ld_v = 32'h0; fi_v = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      bus.in_fetcher_ready = (c <= 3);
      @(negedge clk);
      if (c == 1) chk("simul_busy_welcome", 32'(bus.welcome_lsb), 32'h0);
      if (bus.out_lsb_ready && lsb_c < 0) begin lsb_c = c; ld_v = bus.data_out; end
      if (bus.out_fetcher_ready && f_c < 0) begin f_c = c; fi_v = bus.instr_out; end
      @(posedge clk); #1;
    end
    chk("simul_lsb_c", 32'(lsb_c), 32'd2);
    chk("simul_lsb_data", ld_v, 32'h80);
    chk("simul_fetch_c", 32'(f_c), 32'd4);
    chk("simul_fetch_word", fi_v, 32'hDEADBEEF);

    // rdy low mid-load: pause plus one re-read cycle
    do_op(1, 0, 3'd2, 32'h1000, 32'h0, 0, 0, 3, 4, 30, lat, rd);
    chk("rdy_pause_lat", 32'(lat), 32'd8);
    chk("rdy_pause_data", rd, 32'h13121110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
